dmem_responder: RTL and testbench

Data-memory responder for the Y86-64 SEQ datapath. It serves the memory stage's 64-bit read and write requests through a valid/ready request channel and a valid/ready response channel. Latency is configurable and addresses are bounds-checked. It holds the byte-addressable data store that rmmovq, mrmovq, call, ret, pushq and popq access.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressable Y86-64 data store behind a valid/ready
// request channel and a valid/ready response channel.
// One request outstanding at a time. Response after LATENCY cycles.
// Quadwords are little-endian. Out-of-range accesses report resp_error.
// Optional feature macro: DMEM_ALIGN_CHECK_EN.
// When defined, a nonzero req_addr[2:0] is also an error.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// BUSY  | latency countdown
// RESP  | response held on resp_* until resp_ready
module dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [63:0]   LAST_BASE = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_mem [MEM_BYTES];

  logic          w_accept;
  logic          w_commit;
  logic          w_c_write;
  logic [63:0]   w_c_addr;
  logic [63:0]   w_c_wdata;
  logic [AW-1:0] w_base;
  logic          w_err;
  logic [63:0]   w_rd;

  assign w_accept = req_valid && req_ready;

  // The commit happens on the edge that enters RESP.
  // With LATENCY==1 that edge is the acceptance edge.
  // At that edge the request is still on the inputs and not yet in r_*.
  assign w_commit  = (w_next == ST_RESP) && (r_state != ST_RESP);
  assign w_c_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_c_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_c_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_base    = w_c_addr[AW-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
  end

  // Latency down-counter, loaded on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_cnt <= '0;
    else if (r_state == ST_IDLE && w_accept)    r_cnt <= CNT_LOAD;
    else if (r_state == ST_BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Request capture; the req_* inputs are ignored until the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Error check on the committing address. It is a full 64-bit compare, so it never wraps.
  always_comb begin
    w_err = (w_c_addr > LAST_BASE);
`ifdef DMEM_ALIGN_CHECK_EN
    w_err = w_err || (w_c_addr[2:0] != 3'd0);
`endif
  end

  // Little-endian quadword read from the store
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < 8; i++) begin
      w_rd[8*i +: 8] = r_mem[w_base + AW'(i)];
    end
  end

  // Store update.
  // The rst_n gate stops a LATENCY==1 write from landing while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_c_write && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_base + AW'(i)] <= w_c_wdata[8*i +: 8];
      end
    end
  end

  // Response registers: loaded at commit, held under backpressure, cleared after handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (w_commit) begin
      resp_error <= w_err;
      resp_rdata <= (w_err || w_c_write) ? 64'd0 : w_rd;
    end else if (resp_valid && resp_ready) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int MEMB = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [63:0] req_addr, req_wdata, resp_rdata;

  logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_error1;
  logic [63:0] req_addr1, req_wdata1, resp_rdata1;

  dmem_responder #(.MEM_BYTES(MEMB), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  dmem_responder #(.MEM_BYTES(MEMB), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_error(resp_error1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference byte stores: [0] mirrors dut, [1] mirrors dut1
  logic [7:0] m_mem [2][MEMB];

  // Reference behaviour of one access: the error rule, then a little-endian byte copy
  task automatic model_access(input int id, input logic wr, input logic [63:0] a,
                              input logic [63:0] d, output logic [63:0] rd, output logic er);
    er = (a > 64'(MEMB - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    if ((a % 8) != 0) er = 1'b1;
`endif
    rd = 64'd0;
    if (!er) begin
      for (int i = 0; i < 8; i++) begin
        if (wr) m_mem[id][int'(a) + i] = d[8*i +: 8];
        else    rd = rd | (64'(m_mem[id][int'(a) + i]) << (8*i));
      end
    end
  endtask

  // Drives one request on dut with resp_ready high. Call and return at a negedge.
  // lat counts cycles from the acceptance cycle to the first cycle with resp_valid.
  task automatic do_req(input logic wr, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int lat);
    int n;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0; req_write = ~wr;
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      end
    end while (!resp_valid && lat < 50);
    rd = resp_rdata;
    er = resp_error;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; resp_ready1 = 1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready);
      else n_pass++;
      n_checks++;
      if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid);
      else n_pass++;
      n_checks++;
      if (resp_rdata !== 64'd0 || resp_error !== 1'b0)
        $display("FAIL reset_resp_data: got %h/%b expected 0/0", resp_rdata, resp_error);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  // Writes every quadword so the reference store is fully known
  task automatic test_fill;
    logic [63:0] rd, erd, d;
    logic er, eer;
    int lat;
    for (int q = 0; q < MEMB / 8; q++) begin
      d = {$urandom, $urandom};
      do_req(1'b1, 64'(q * 8), d, rd, er, lat);
      model_access(0, 1'b1, 64'(q * 8), d, erd, eer);
      n_checks++;
      if (rd !== erd || er !== eer)
        $display("FAIL fill_resp @%0h: got %h/%b expected %h/%b", q * 8, rd, er, erd, eer);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL fill_latency: got %0d expected 2", lat);
      else n_pass++;
    end
  endtask

  task automatic test_write_read;
    logic        t_wr [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] t_a  [5] = '{64'h40, 64'h40, 64'h48, 64'h41, 64'h48};
    logic [63:0] t_d  [5] = '{64'h1122334455667788, 64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] rd, erd;
    logic er, eer;
    int lat;
    for (int k = 0; k < 5; k++) begin
      do_req(t_wr[k], t_a[k], t_d[k], rd, er, lat);
      model_access(0, t_wr[k], t_a[k], t_d[k], erd, eer);
      n_checks++;
      if (rd !== erd) $display("FAIL wr_rd_data #%0d: got %h expected %h", k, rd, erd);
      else n_pass++;
      n_checks++;
      if (er !== eer) $display("FAIL wr_rd_error #%0d: got %b expected %b", k, er, eer);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL wr_rd_latency #%0d: got %0d expected 2", k, lat);
      else n_pass++;
    end
  endtask

  task automatic test_boundary;
    logic        t_wr [10] = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    logic [63:0] t_a  [10] = '{64'h3F8, 64'h3F8, 64'h3F9, 64'h3F9, 64'h3F8,
                               64'h400, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF8,
                               64'h3FC, 64'h3F0};
    logic [63:0] rd, erd, d;
    logic er, eer;
    int lat;
    for (int k = 0; k < 10; k++) begin
      d = {$urandom, $urandom};
      do_req(t_wr[k], t_a[k], d, rd, er, lat);
      model_access(0, t_wr[k], t_a[k], d, erd, eer);
      n_checks++;
      if (rd !== erd || er !== eer)
        $display("FAIL boundary @%h: got %h/%b expected %h/%b", t_a[k], rd, er, erd, eer);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, erd, d, a;
    logic er, eer, wr;
    int lat, sel;
    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = 64'($urandom_range(0, MEMB / 8 - 1)) << 3;
      else if (sel < 8) a = 64'($urandom_range(0, MEMB - 8));
      else if (sel < 9) a = 64'($urandom_range(MEMB - 7, MEMB + 64));
      else              a = {$urandom, $urandom};
      wr = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      do_req(wr, a, d, rd, er, lat);
      model_access(0, wr, a, d, erd, eer);
      n_checks++;
      if (rd !== erd || er !== eer)
        $display("FAIL random #%0d wr=%b @%h: got %h/%b expected %h/%b", k, wr, a, rd, er, erd, eer);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL random_latency #%0d: got %0d expected 2", k, lat);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] t_a [2] = '{64'h1A8, 64'h3F9};
    logic [63:0] erd;
    logic eer;
    int n;
    for (int j = 0; j < 2; j++) begin
      model_access(0, 1'b0, t_a[j], 64'd0, erd, eer);
      req_valid = 1'b1; req_write = 1'b0; req_addr = t_a[j]; resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      req_valid = 1'b0; req_addr = {$urandom, $urandom};
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge clk); n++; end
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0)
          $display("FAIL bp_hold_handshake: got valid=%b ready=%b expected 1/0", resp_valid, req_ready);
        else n_pass++;
        n_checks++;
        if (resp_rdata !== erd || resp_error !== eer)
          $display("FAIL bp_hold_data: got %h/%b expected %h/%b", resp_rdata, resp_error, erd, eer);
        else n_pass++;
        @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
        $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
      else n_pass++;
    end
  endtask

  task automatic test_midreset;
    logic [63:0] rd, erd;
    logic er, eer;
    int lat, n;
    model_access(0, 1'b0, 64'h80, 64'd0, erd, eer);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h80; req_wdata = 64'hDEAD; resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL midrst_busy: got ready=%b valid=%b expected 0/0", req_ready, resp_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_error !== 1'b0)
      $display("FAIL midrst_outputs: got %b/%b/%h/%b expected 1/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_error);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(1'b0, 64'h80, 64'd0, rd, er, lat);
    n_checks++;
    if (rd !== erd || er !== eer)
      $display("FAIL midrst_no_write: got %h/%b expected %h/%b", rd, er, erd, eer);
    else n_pass++;

    // Reset while a response is pending: it must be dropped
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h88; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || req_ready !== 1'b1)
      $display("FAIL midrst_resp_drop: got %b/%h/%b expected 0/0/1", resp_valid, resp_rdata, req_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_access(0, 1'b0, 64'h88, 64'd0, erd, eer);
    do_req(1'b0, 64'h88, 64'd0, rd, er, lat);
    n_checks++;
    if (rd !== erd || er !== eer || lat !== 2)
      $display("FAIL midrst_recover: got %h/%b lat %0d expected %h/%b lat 2", rd, er, lat, erd, eer);
    else n_pass++;
  endtask

  task automatic test_lat1;
    logic        t_wr [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [63:0] t_a  [9] = '{64'h10, 64'h18, 64'h3F8, 64'h100, 64'h3F8, 64'h10, 64'h100, 64'h18, 64'h3F9};
    logic [63:0] t_d  [9];
    logic [63:0] q_rd [$];
    logic        q_er [$];
    int          q_cyc [$];
    logic [63:0] erd, exp_rd;
    logic eer, exp_er, acc;
    int cyc, k, nresp, last, acc_cyc;
    for (int i = 0; i < 9; i++) t_d[i] = {$urandom, $urandom};
    cyc = 0; k = 0; nresp = 0; last = -1;
    resp_ready1 = 1'b1;
    req_valid1 = 1'b1; req_write1 = t_wr[0]; req_addr1 = t_a[0]; req_wdata1 = t_d[0];
    while (nresp < 9 && cyc < 100) begin
      if (resp_valid1) begin
        n_checks++;
        if (q_rd.size() == 0) $display("FAIL lat1_unexpected_resp: got response at cycle %0d expected none", cyc);
        else begin
          n_pass++;
          exp_rd = q_rd.pop_front(); exp_er = q_er.pop_front(); acc_cyc = q_cyc.pop_front();
          n_checks++;
          if (resp_rdata1 !== exp_rd || resp_error1 !== exp_er)
            $display("FAIL lat1_data #%0d: got %h/%b expected %h/%b", nresp, resp_rdata1, resp_error1, exp_rd, exp_er);
          else n_pass++;
          n_checks++;
          if (cyc - acc_cyc !== 1)
            $display("FAIL lat1_latency #%0d: got %0d expected 1", nresp, cyc - acc_cyc);
          else n_pass++;
          if (last >= 0) begin
            n_checks++;
            if (cyc - last !== 2) $display("FAIL lat1_spacing #%0d: got %0d expected 2", nresp, cyc - last);
            else n_pass++;
          end
        end
        last = cyc;
        nresp++;
      end
      acc = req_valid1 && req_ready1;
      if (acc) begin
        model_access(1, t_wr[k], t_a[k], t_d[k], erd, eer);
        q_rd.push_back(erd); q_er.push_back(eer); q_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 9) begin
          req_write1 = t_wr[k]; req_addr1 = t_a[k]; req_wdata1 = t_d[k];
        end else req_valid1 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (nresp !== 9) $display("FAIL lat1_count: got %0d responses expected 9", nresp);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_read;
    test_boundary;
    test_random;
    test_backpressure;
    test_midreset;
    test_lat1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
